exe_mem_stage: RTL and testbench

- Execute stage of the 16-bit five-stage pipeline, fused with the EXE/MEM pipeline register.
- Takes the operands, immediate, PC, destination register and control bits latched by the ID/EXE register.
- Computes the ALU result combinationally; this result is also exported for forwarding back to ID.
- On each clock edge, captures everything the MEM stage needs.
- The clock is generated outside this block.

---
 rtl/exe_mem_stage.sv | 85 ++++++++
 tb/tb_exe_mem_stage.sv | 98 +++++++++
 2 files changed

// File: rtl/exe_mem_stage.sv
// Execute stage of the 16-bit pipeline fused with the EXE/MEM register.
// The ALU result is exported combinationally for forwarding; everything MEM needs is captured each edge.
module exe_mem_stage #(
    parameter int DATA_W   = 16,
    parameter int REG_W    = 3,
    parameter int MEMSIG_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     immediate_EXE,
    input  logic [DATA_W-1:0]     valueA_EXE,
    input  logic [DATA_W-1:0]     valueB_EXE,
    input  logic [DATA_W-1:0]     PC_EXE,
    input  logic [REG_W-1:0]      Rd_EXE,
    input  logic [MEMSIG_W+2:0]   EXE_signals,
    output logic [DATA_W-1:0]     AluResult_EXE,
    output logic [DATA_W-1:0]     AluResult_MEM,
    output logic [DATA_W-1:0]     valueB_MEM,
    output logic [DATA_W-1:0]     immediate_MEM,
    output logic [DATA_W-1:0]     PC_MEM,
    output logic [REG_W-1:0]      Rd_MEM,
    output logic [MEMSIG_W-1:0]   MEM_signals
);

    typedef enum logic [1:0] {
        ALU_AND  = 2'b00,
        ALU_ADD  = 2'b01,
        ALU_SUB  = 2'b10,
        ALU_PASS = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic [DATA_W-1:0]   alu;
        logic [DATA_W-1:0]   valb;
        logic [DATA_W-1:0]   imm;
        logic [DATA_W-1:0]   pc;
        logic [REG_W-1:0]    rd;
        logic [MEMSIG_W-1:0] sig;
    } exe_mem_t;

    logic              alu_src;
    alu_op_e           alu_op;
    logic [DATA_W-1:0] op_b;
    exe_mem_t          pl_d, pl_q;

    assign alu_src = EXE_signals[MEMSIG_W+2];
    assign alu_op  = alu_op_e'(EXE_signals[MEMSIG_W+1:MEMSIG_W]);
    assign op_b    = alu_src ? immediate_EXE : valueB_EXE;

    // Carry/borrow fall off the top: results are modulo 2^DATA_W, no flags.
    always_comb begin
        AluResult_EXE = '0;
        case (alu_op)
            ALU_AND:  AluResult_EXE = valueA_EXE & op_b;
            ALU_ADD:  AluResult_EXE = valueA_EXE + op_b;
            ALU_SUB:  AluResult_EXE = valueA_EXE - op_b;
            ALU_PASS: AluResult_EXE = op_b;
            default:  AluResult_EXE = '0;
        endcase
    end

    always_comb begin
        pl_d      = '0;
        pl_d.alu  = AluResult_EXE;
        pl_d.valb = valueB_EXE;
        pl_d.imm  = immediate_EXE;
        pl_d.pc   = PC_EXE;
        pl_d.rd   = Rd_EXE;
        pl_d.sig  = EXE_signals[MEMSIG_W-1:0];
    end

    // No enable: bubbles arrive as zero control bits and flow through as-is.
    always_ff @(posedge clk) begin
        if (reset) pl_q <= '0;
        else       pl_q <= pl_d;
    end

    assign AluResult_MEM = pl_q.alu;
    assign valueB_MEM    = pl_q.valb;
    assign immediate_MEM = pl_q.imm;
    assign PC_MEM        = pl_q.pc;
    assign Rd_MEM        = pl_q.rd;
    assign MEM_signals   = pl_q.sig;

endmodule

// File: tb/tb_exe_mem_stage.sv
// Directed-vector bench for exe_mem_stage: hand-computed ALU results and one-cycle register checks.
module tb_exe_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] immediate_EXE, valueA_EXE, valueB_EXE, PC_EXE;
    logic [2:0]  Rd_EXE;
    logic [10:0] EXE_signals;
    logic [15:0] AluResult_EXE, AluResult_MEM, valueB_MEM, immediate_MEM, PC_MEM;
    logic [2:0]  Rd_MEM;
    logic [7:0]  MEM_signals;

    int n_vec = 0;
    int n_err = 0;

    exe_mem_stage dut (
        .clk(clk), .reset(reset),
        .immediate_EXE(immediate_EXE), .valueA_EXE(valueA_EXE), .valueB_EXE(valueB_EXE),
        .PC_EXE(PC_EXE), .Rd_EXE(Rd_EXE), .EXE_signals(EXE_signals),
        .AluResult_EXE(AluResult_EXE), .AluResult_MEM(AluResult_MEM), .valueB_MEM(valueB_MEM),
        .immediate_MEM(immediate_MEM), .PC_MEM(PC_MEM), .Rd_MEM(Rd_MEM), .MEM_signals(MEM_signals)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [15:0] imm,
                         input logic [15:0] pc, input logic [2:0] rd, input logic [10:0] sig);
        valueA_EXE = a; valueB_EXE = b; immediate_EXE = imm;
        PC_EXE = pc; Rd_EXE = rd; EXE_signals = sig;
    endtask

    task automatic chk_mem(input string tag, input logic [15:0] alu, input logic [15:0] b,
                           input logic [15:0] imm, input logic [15:0] pc, input logic [2:0] rd,
                           input logic [7:0] ms);
        chk({tag, ".alu_mem"}, AluResult_MEM, alu);
        chk({tag, ".valb_mem"}, valueB_MEM, b);
        chk({tag, ".imm_mem"}, immediate_MEM, imm);
        chk({tag, ".pc_mem"}, PC_MEM, pc);
        chk({tag, ".rd_mem"}, {13'd0, Rd_MEM}, {13'd0, rd});
        chk({tag, ".sig_mem"}, {8'd0, MEM_signals}, {8'd0, ms});
    endtask

    // Called at a negedge: apply inputs, check the forwarding result, then the registered set.
    task automatic step(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] imm, input logic [15:0] pc, input logic [2:0] rd,
                        input logic [10:0] sig, input logic [15:0] exp_alu, input logic [7:0] exp_ms);
        drive(a, b, imm, pc, rd, sig);
        #1 chk({tag, ".alu_exe"}, AluResult_EXE, exp_alu);
        @(negedge clk);
        chk_mem(tag, exp_alu, b, imm, pc, rd, exp_ms);
    endtask

    initial begin
        reset = 1'b1;
        drive(16'h1111, 16'h2222, 16'h3333, 16'h4444, 3'd7, 11'h7FF);
        @(negedge clk);
        chk_mem("rst0", 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 8'h00);
        reset = 1'b0;

        //   tag        A        valueB   imm      PC       Rd    signals  alu      MEM
        step("add",    16'h0005, 16'h0003, 16'h0000, 16'h0010, 3'd3, 11'h101, 16'h0008, 8'h01);
        step("sub0",   16'h0000, 16'h0001, 16'h0000, 16'h0012, 3'd1, 11'h200, 16'hFFFF, 8'h00);
        step("sub8k",  16'h8000, 16'h0001, 16'h0000, 16'h0014, 3'd2, 11'h240, 16'h7FFF, 8'h40);
        step("andi",   16'h00FF, 16'hFFFF, 16'h0F0F, 16'h0016, 3'd4, 11'h441, 16'h000F, 8'h41);
        step("passi",  16'h5555, 16'hAAAA, 16'h1234, 16'h0018, 3'd5, 11'h781, 16'h1234, 8'h81);
        step("addi",   16'hFFFF, 16'h7777, 16'h0002, 16'h001A, 3'd6, 11'h501, 16'h0001, 8'h01);
        step("andr",   16'hF0F0, 16'h3C3C, 16'hFFFF, 16'h001C, 3'd7, 11'h0FF, 16'h3030, 8'hFF);
        step("passr",  16'h0000, 16'hBEEF, 16'h1111, 16'h001E, 3'd2, 11'h300, 16'hBEEF, 8'h00);
        step("bubble", 16'h0001, 16'h0002, 16'h0000, 16'h0020, 3'd0, 11'h000, 16'h0000, 8'h00);
        step("pre",    16'h0100, 16'h0023, 16'h0000, 16'h0030, 3'd3, 11'h1C1, 16'h0123, 8'hC1);

        // Reset mid-stream: the ALU still follows its inputs, the register is cleared.
        reset = 1'b1;
        drive(16'h0005, 16'h0003, 16'h0000, 16'h0032, 3'd3, 11'h101);
        #1 chk("rstmid.alu_exe", AluResult_EXE, 16'h0008);
        @(negedge clk);
        chk_mem("rstmid", 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 8'h00);
        drive(16'h000A, 16'h0004, 16'h0000, 16'h0034, 3'd1, 11'h200);
        #1 chk("rsthold.alu_exe", AluResult_EXE, 16'h0006);
        reset = 1'b0;
        @(negedge clk);
        chk_mem("rstrel", 16'h0006, 16'h0004, 16'h0000, 16'h0034, 3'd1, 8'h00);

        step("post",   16'h1000, 16'h0234, 16'h0000, 16'h0040, 3'd5, 11'h1A5, 16'h1234, 8'hA5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
